// File: rtl/rcu_pkg.sv
// Shared RCU types: architectural/physical tag widths and the packed map-table type.
package rcu_pkg;

  localparam int ARCH_REG_WIDTH = 5;
  localparam int ARCH_REG_NUM   = 32;
  localparam int PHY_REG_WIDTH  = 6;
  localparam int RD_PORTS       = 6;

  typedef logic [ARCH_REG_WIDTH-1:0] arch_tag_t;
  typedef logic [PHY_REG_WIDTH-1:0]  phy_tag_t;
  typedef logic [ARCH_REG_NUM-1:0][PHY_REG_WIDTH-1:0] rat_t;

  function automatic rat_t identity_map();
    rat_t m;
    for (int i = 0; i < ARCH_REG_NUM; i++) begin
      m[i] = phy_tag_t'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/rcu_map_table.sv
// Rename map table: 6 combinational read ports, 2 write ports (slot 1 wins),
// a bulk-load port that overrides writes, and async reset to the identity map.
module rcu_map_table
  import rcu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  arch_tag_t [RD_PORTS-1:0] rd_addr,
  output phy_tag_t  [RD_PORTS-1:0] rd_data,
  input  logic                     wr_first_en,
  input  arch_tag_t                wr_first_addr,
  input  phy_tag_t                 wr_first_data,
  input  logic                     wr_second_en,
  input  arch_tag_t                wr_second_addr,
  input  phy_tag_t                 wr_second_data,
  input  logic                     load_en,
  input  rat_t                     load_data,
  output rat_t                     next_map
);

  rat_t map_q;

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_data[i] = map_q[rd_addr[i]];
    end
  end

  // next_map is also the post-write view a flush restores from
  always_comb begin
    next_map = map_q;
    if (wr_first_en)  next_map[wr_first_addr]  = wr_first_data;
    if (wr_second_en) next_map[wr_second_addr] = wr_second_data;
    if (load_en)      next_map = load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) map_q <= identity_map();
    else     map_q <= next_map;
  end

endmodule

// File: rtl/rcu_rename_table.sv
// Dual-issue register rename table (speculative + architectural RAT).
// Optional RCU_RAT_STALL_CNT_EN adds a saturating rename-stall counter output.
module rcu_rename_table
  import rcu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      excep_rst_i,
  input  logic      rename_first_en_i,
  input  logic      rename_second_en_i,
  input  arch_tag_t rs1_first_i,
  input  arch_tag_t rs2_first_i,
  input  arch_tag_t rd_first_i,
  input  arch_tag_t rs1_second_i,
  input  arch_tag_t rs2_second_i,
  input  arch_tag_t rd_second_i,
  input  phy_tag_t  fl_rdata_first_i,
  input  phy_tag_t  fl_rdata_second_i,
  input  logic      fl_empty_i,
  input  logic      fl_almost_empty_i,
  output logic      fl_rd_first_en_o,
  output logic      fl_rd_second_en_o,
  output logic      rename_ready_o,
  output phy_tag_t  prs1_first_o,
  output phy_tag_t  prs2_first_o,
  output phy_tag_t  prd_first_o,
  output phy_tag_t  old_prd_first_o,
  output phy_tag_t  prs1_second_o,
  output phy_tag_t  prs2_second_o,
  output phy_tag_t  prd_second_o,
  output phy_tag_t  old_prd_second_o,
  input  logic      commit_first_en_i,
  input  logic      commit_second_en_i,
  input  arch_tag_t commit_rd_first_i,
  input  arch_tag_t commit_rd_second_i,
  input  phy_tag_t  commit_prd_first_i,
  input  phy_tag_t  commit_prd_second_i,
  input  phy_tag_t  commit_old_prd_first_i,
  input  phy_tag_t  commit_old_prd_second_i,
  output logic      fl_wr_first_en_o,
  output logic      fl_wr_second_en_o,
  output phy_tag_t  fl_wdata_first_o,
  output phy_tag_t  fl_wdata_second_o,
  output logic      fl_rd_excep_first_en_o,
  output logic      fl_rd_excep_second_en_o
`ifdef RCU_RAT_STALL_CNT_EN
  ,
  output logic [31:0] rename_stall_cnt_o
`endif
);

  logic need0, need1, ready;
  logic commit0, commit1;
  arch_tag_t [RD_PORTS-1:0] spec_addr;
  phy_tag_t  [RD_PORTS-1:0] spec_data;
  rat_t arch_next;

  assign need0   = rename_first_en_i  && (rd_first_i  != '0);
  assign need1   = rename_second_en_i && (rd_second_i != '0);
  assign commit0 = commit_first_en_i  && (commit_rd_first_i  != '0);
  assign commit1 = commit_second_en_i && (commit_rd_second_i != '0);

  always_comb begin
    ready = 1'b0;
    if (!rst && !excep_rst_i) begin
      case ({need0, need1})
        2'b00:   ready = 1'b1;
        2'b11:   ready = !fl_almost_empty_i;
        default: ready = !fl_empty_i;
      endcase
    end
  end

  assign rename_ready_o    = ready;
  assign fl_rd_first_en_o  = need0 && ready;
  assign fl_rd_second_en_o = need1 && ready;

  assign spec_addr = {rd_second_i, rs2_second_i, rs1_second_i,
                      rd_first_i,  rs2_first_i,  rs1_first_i};

  assign prd_first_o  = (rd_first_i  != '0) ? fl_rdata_first_i  : '0;
  assign prd_second_o = (rd_second_i != '0) ? fl_rdata_second_i : '0;

  // Slot 1 sees slot 0's new destination tag within the same group
  always_comb begin
    prs1_first_o    = (rs1_first_i != '0) ? spec_data[0] : '0;
    prs2_first_o    = (rs2_first_i != '0) ? spec_data[1] : '0;
    old_prd_first_o = (rd_first_i  != '0) ? spec_data[2] : '0;

    prs1_second_o = spec_data[3];
    if (rs1_second_i == '0)                       prs1_second_o = '0;
    else if (need0 && rs1_second_i == rd_first_i) prs1_second_o = prd_first_o;

    prs2_second_o = spec_data[4];
    if (rs2_second_i == '0)                       prs2_second_o = '0;
    else if (need0 && rs2_second_i == rd_first_i) prs2_second_o = prd_first_o;

    old_prd_second_o = spec_data[5];
    if (rd_second_i == '0)                       old_prd_second_o = '0;
    else if (need0 && rd_second_i == rd_first_i) old_prd_second_o = prd_first_o;
  end

  rcu_map_table u_spec_rat (
    .clk            (clk),
    .rst            (rst),
    .rd_addr        (spec_addr),
    .rd_data        (spec_data),
    .wr_first_en    (need0 && ready),
    .wr_first_addr  (rd_first_i),
    .wr_first_data  (prd_first_o),
    .wr_second_en   (need1 && ready),
    .wr_second_addr (rd_second_i),
    .wr_second_data (prd_second_o),
    .load_en        (excep_rst_i),
    .load_data      (arch_next),
    .next_map       ()
  );

  rcu_map_table u_arch_rat (
    .clk            (clk),
    .rst            (rst),
    .rd_addr        ('0),
    .rd_data        (),
    .wr_first_en    (commit0),
    .wr_first_addr  (commit_rd_first_i),
    .wr_first_data  (commit_prd_first_i),
    .wr_second_en   (commit1),
    .wr_second_addr (commit_rd_second_i),
    .wr_second_data (commit_prd_second_i),
    .load_en        (1'b0),
    .load_data      ('0),
    .next_map       (arch_next)
  );

  assign fl_wr_first_en_o        = commit0 && !rst;
  assign fl_wr_second_en_o       = commit1 && !rst;
  assign fl_wdata_first_o        = commit_old_prd_first_i;
  assign fl_wdata_second_o       = commit_old_prd_second_i;
  assign fl_rd_excep_first_en_o  = commit0 && !rst;
  assign fl_rd_excep_second_en_o = commit1 && !rst;

`ifdef RCU_RAT_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rename_stall_cnt_o <= '0;
    end else if ((rename_first_en_i || rename_second_en_i) && !ready && !excep_rst_i
                 && rename_stall_cnt_o != '1) begin
      rename_stall_cnt_o <= rename_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rcu_rename_table.sv
// Directed self-checking bench for rcu_rename_table; build with
// +define+RCU_RAT_STALL_CNT_EN to also check the stall counter.
module tb_rcu_rename_table;
  import rcu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic excep_rst_i;
  logic rename_first_en_i, rename_second_en_i;
  arch_tag_t rs1_first_i, rs2_first_i, rd_first_i;
  arch_tag_t rs1_second_i, rs2_second_i, rd_second_i;
  phy_tag_t fl_rdata_first_i, fl_rdata_second_i;
  logic fl_empty_i, fl_almost_empty_i;
  logic fl_rd_first_en_o, fl_rd_second_en_o, rename_ready_o;
  phy_tag_t prs1_first_o, prs2_first_o, prd_first_o, old_prd_first_o;
  phy_tag_t prs1_second_o, prs2_second_o, prd_second_o, old_prd_second_o;
  logic commit_first_en_i, commit_second_en_i;
  arch_tag_t commit_rd_first_i, commit_rd_second_i;
  phy_tag_t commit_prd_first_i, commit_prd_second_i;
  phy_tag_t commit_old_prd_first_i, commit_old_prd_second_i;
  logic fl_wr_first_en_o, fl_wr_second_en_o;
  phy_tag_t fl_wdata_first_o, fl_wdata_second_o;
  logic fl_rd_excep_first_en_o, fl_rd_excep_second_en_o;
`ifdef RCU_RAT_STALL_CNT_EN
  logic [31:0] rename_stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rcu_rename_table dut (
    .clk(clk), .rst(rst), .excep_rst_i(excep_rst_i),
    .rename_first_en_i(rename_first_en_i), .rename_second_en_i(rename_second_en_i),
    .rs1_first_i(rs1_first_i), .rs2_first_i(rs2_first_i), .rd_first_i(rd_first_i),
    .rs1_second_i(rs1_second_i), .rs2_second_i(rs2_second_i), .rd_second_i(rd_second_i),
    .fl_rdata_first_i(fl_rdata_first_i), .fl_rdata_second_i(fl_rdata_second_i),
    .fl_empty_i(fl_empty_i), .fl_almost_empty_i(fl_almost_empty_i),
    .fl_rd_first_en_o(fl_rd_first_en_o), .fl_rd_second_en_o(fl_rd_second_en_o),
    .rename_ready_o(rename_ready_o),
    .prs1_first_o(prs1_first_o), .prs2_first_o(prs2_first_o),
    .prd_first_o(prd_first_o), .old_prd_first_o(old_prd_first_o),
    .prs1_second_o(prs1_second_o), .prs2_second_o(prs2_second_o),
    .prd_second_o(prd_second_o), .old_prd_second_o(old_prd_second_o),
    .commit_first_en_i(commit_first_en_i), .commit_second_en_i(commit_second_en_i),
    .commit_rd_first_i(commit_rd_first_i), .commit_rd_second_i(commit_rd_second_i),
    .commit_prd_first_i(commit_prd_first_i), .commit_prd_second_i(commit_prd_second_i),
    .commit_old_prd_first_i(commit_old_prd_first_i),
    .commit_old_prd_second_i(commit_old_prd_second_i),
    .fl_wr_first_en_o(fl_wr_first_en_o), .fl_wr_second_en_o(fl_wr_second_en_o),
    .fl_wdata_first_o(fl_wdata_first_o), .fl_wdata_second_o(fl_wdata_second_o),
    .fl_rd_excep_first_en_o(fl_rd_excep_first_en_o),
    .fl_rd_excep_second_en_o(fl_rd_excep_second_en_o)
`ifdef RCU_RAT_STALL_CNT_EN
    , .rename_stall_cnt_o(rename_stall_cnt_o)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clearInputs();
    excep_rst_i = 0;
    rename_first_en_i = 0; rename_second_en_i = 0;
    rs1_first_i = 0; rs2_first_i = 0; rd_first_i = 0;
    rs1_second_i = 0; rs2_second_i = 0; rd_second_i = 0;
    fl_rdata_first_i = 0; fl_rdata_second_i = 0;
    fl_empty_i = 0; fl_almost_empty_i = 0;
    commit_first_en_i = 0; commit_second_en_i = 0;
    commit_rd_first_i = 0; commit_rd_second_i = 0;
    commit_prd_first_i = 0; commit_prd_second_i = 0;
    commit_old_prd_first_i = 0; commit_old_prd_second_i = 0;
  endtask

  // Drive both rename slots, then let the combinational outputs settle
  task automatic applyStimulus(input logic en0, input int s1a, input int s2a, input int rda, input int da,
                               input logic en1, input int s1b, input int s2b, input int rdb, input int db);
    rename_first_en_i = en0;
    rs1_first_i = arch_tag_t'(s1a); rs2_first_i = arch_tag_t'(s2a); rd_first_i = arch_tag_t'(rda);
    fl_rdata_first_i = phy_tag_t'(da);
    rename_second_en_i = en1;
    rs1_second_i = arch_tag_t'(s1b); rs2_second_i = arch_tag_t'(s2b); rd_second_i = arch_tag_t'(rdb);
    fl_rdata_second_i = phy_tag_t'(db);
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  initial begin
    clearInputs();
    rst = 1;
    #2;
    applyStimulus(1, 2, 3, 1, 32, 0, 0, 0, 0, 0);
    checkOutput("rst_ready", rename_ready_o, 0);
    checkOutput("rst_pop0", fl_rd_first_en_o, 0);
    checkOutput("rst_prs1_identity", prs1_first_o, 2);
    commit_first_en_i = 1; commit_rd_first_i = 7; #1;
    checkOutput("rst_fl_wr0", fl_wr_first_en_o, 0);
    nextCycle();
    nextCycle();
    rst = 0;

    applyStimulus(1, 2, 3, 1, 32, 0, 0, 0, 0, 0);
    checkOutput("t1_prs1", prs1_first_o, 2);
    checkOutput("t1_prs2", prs2_first_o, 3);
    checkOutput("t1_prd", prd_first_o, 32);
    checkOutput("t1_old_prd", old_prd_first_o, 1);
    checkOutput("t1_pop0", fl_rd_first_en_o, 1);
    checkOutput("t1_pop1", fl_rd_second_en_o, 0);
    checkOutput("t1_ready", rename_ready_o, 1);
    nextCycle();

    applyStimulus(1, 1, 0, 0, 9, 0, 0, 0, 0, 0);
    checkOutput("t2_prs1_b2b", prs1_first_o, 32);
    checkOutput("t2_prs2_x0", prs2_first_o, 0);
    checkOutput("t2_prd_x0", prd_first_o, 0);
    checkOutput("t2_old_x0", old_prd_first_o, 0);
    checkOutput("t2_nopop", fl_rd_first_en_o, 0);
    nextCycle();

    applyStimulus(1, 0, 0, 5, 40, 1, 5, 1, 5, 41);
    checkOutput("t3_bypass_prs1", prs1_second_o, 40);
    checkOutput("t3_prs2_second", prs2_second_o, 32);
    checkOutput("t3_bypass_old", old_prd_second_o, 40);
    checkOutput("t3_prd_second", prd_second_o, 41);
    checkOutput("t3_old_first", old_prd_first_o, 5);
    checkOutput("t3_pops", {fl_rd_first_en_o, fl_rd_second_en_o}, 2'b11);
    nextCycle();

    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_slot1_wins", prs1_first_o, 41);
    nextCycle();

    fl_almost_empty_i = 1;
    applyStimulus(1, 0, 0, 6, 20, 1, 0, 0, 9, 21);
    checkOutput("t5_stall_ready", rename_ready_o, 0);
    checkOutput("t5_stall_pops", {fl_rd_first_en_o, fl_rd_second_en_o}, 2'b00);
    nextCycle();

    fl_empty_i = 1;
    applyStimulus(1, 6, 9, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_x6_unchanged", prs1_first_o, 6);
    checkOutput("t6_x9_unchanged", prs2_first_o, 9);
    checkOutput("t6_x0_ready_empty", rename_ready_o, 1);
    checkOutput("t6_x0_nopop", fl_rd_first_en_o, 0);
    applyStimulus(1, 0, 0, 3, 33, 0, 0, 0, 0, 0);
    checkOutput("t6_one_empty", rename_ready_o, 0);
    fl_empty_i = 0; fl_almost_empty_i = 1; #1;
    checkOutput("t6_one_almost", rename_ready_o, 1);
    checkOutput("t6_one_almost_pop", fl_rd_first_en_o, 1);
    nextCycle();

    commit_first_en_i = 1; commit_rd_first_i = 7; commit_prd_first_i = 45; commit_old_prd_first_i = 7;
    commit_second_en_i = 1; commit_rd_second_i = 0; commit_old_prd_second_i = 12;
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t7_x3_renamed", prs1_first_o, 33);
    checkOutput("t7_fl_wr0", fl_wr_first_en_o, 1);
    checkOutput("t7_fl_wdata0", fl_wdata_first_o, 7);
    checkOutput("t7_fl_excep0", fl_rd_excep_first_en_o, 1);
    checkOutput("t7_fl_wr1_x0", fl_wr_second_en_o, 0);
    checkOutput("t7_fl_excep1_x0", fl_rd_excep_second_en_o, 0);
    nextCycle();

    applyStimulus(1, 7, 0, 7, 50, 0, 0, 0, 0, 0);
    checkOutput("t8_spec_x7_old", prs1_first_o, 7);
    nextCycle();

    applyStimulus(1, 7, 0, 4, 51, 0, 0, 0, 0, 0);
    checkOutput("t9_spec_x7_new", prs1_first_o, 50);
    excep_rst_i = 1;
    commit_first_en_i = 1; commit_rd_first_i = 8; commit_prd_first_i = 46; commit_old_prd_first_i = 8;
    #1;
    checkOutput("t9_excep_ready", rename_ready_o, 0);
    checkOutput("t9_excep_nopop", fl_rd_first_en_o, 0);
    checkOutput("t9_excep_commit", fl_wr_first_en_o, 1);
    nextCycle();

    applyStimulus(1, 7, 8, 1, 55, 1, 5, 3, 0, 0);
    checkOutput("t10_restore_x7", prs1_first_o, 45);
    checkOutput("t10_restore_x8", prs2_first_o, 46);
    checkOutput("t10_restore_x1", old_prd_first_o, 1);
    checkOutput("t10_restore_x5", prs1_second_o, 5);
    checkOutput("t10_restore_x3", prs2_second_o, 3);
    nextCycle();

    fl_empty_i = 1;
    applyStimulus(1, 0, 0, 2, 60, 0, 0, 0, 0, 0);
    nextCycle();
    fl_empty_i = 1;
    applyStimulus(1, 0, 0, 2, 60, 0, 0, 0, 0, 0);
    nextCycle();
`ifdef RCU_RAT_STALL_CNT_EN
    checkOutput("stall_cnt", rename_stall_cnt_o, 3);
`endif

    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pre_rst_x1", prs1_first_o, 55);
    @(negedge clk);
    rst = 1;
    #1;
    checkOutput("mid_rst_x1", prs1_first_o, 1);
    checkOutput("mid_rst_ready", rename_ready_o, 0);
`ifdef RCU_RAT_STALL_CNT_EN
    checkOutput("mid_rst_cnt", rename_stall_cnt_o, 0);
`endif
    nextCycle();
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
